// File: rtl/conv_pkg.sv
// Shared constants, bank-select codes and controller states for the convolution host.
package conv_pkg;
    localparam int DW         = 20;
    localparam int AW         = 12;
    localparam int IMG_WORDS  = 4096;
    localparam int L1_WORDS   = 1024;
    localparam int DUMP_WORDS = IMG_WORDS + L1_WORDS;
    localparam int IMG_AW     = $clog2(IMG_WORDS);
    localparam int L1_AW      = $clog2(L1_WORDS);
    localparam int DCW        = $clog2(DUMP_WORDS);

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef enum logic [2:0] {
        LOAD,
        ARM,
        RUN,
        DUMP,
        FIN
    } state_t;
endpackage

// File: rtl/conv_ram.sv
// Simple RAM: one synchronous write port, one asynchronous read port.
module conv_ram #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 20,
    parameter int ABITS = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [ABITS-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/conv_host.sv
// Host for the convolution engine: loads the image, serves engine memory
// accesses while it runs, then streams both result layers out.
module conv_host
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_sel,
    output logic          out_last,
    output logic          done
);
    state_t              state_reg;
    logic [IMG_AW-1:0]   cnt_reg;
    logic [DCW-1:0]      d_reg;
    logic                in_ready_reg;
    logic                ready_reg;
    logic                done_reg;
    logic                busy_reg;

    logic                img_we;
    logic                l0_we;
    logic                l1_we;
    logic                in_dump;
    logic                dump_l1;
    logic                dump_end;
    logic [DCW-1:0]      d_l1;
    logic [IMG_AW-1:0]   l0_raddr;
    logic [L1_AW-1:0]    l1_raddr;
    logic [DW-1:0]       l0_rdata;
    logic [DW-1:0]       l1_rdata;

    assign img_we   = in_valid & in_ready_reg;
    assign l0_we    = (state_reg == RUN) & cwr & (csel == CSEL_L0);
    assign l1_we    = (state_reg == RUN) & cwr & (csel == CSEL_L1);
    assign in_dump  = (state_reg == DUMP);
    assign dump_l1  = (d_reg >= DCW'(IMG_WORDS));
    assign dump_end = (d_reg == DCW'(DUMP_WORDS - 1));
    assign d_l1     = d_reg - DCW'(IMG_WORDS);

    // Layer read ports belong to the dump counter in DUMP, to the engine otherwise.
    assign l0_raddr = in_dump ? d_reg[IMG_AW-1:0] : caddr_rd[IMG_AW-1:0];
    assign l1_raddr = in_dump ? d_l1[L1_AW-1:0]   : caddr_rd[L1_AW-1:0];

    conv_ram #(.DEPTH(IMG_WORDS), .WIDTH(DW)) u_img (
        .clk   (clk),
        .we    (img_we),
        .waddr (cnt_reg),
        .wdata (in_data),
        .raddr (iaddr[IMG_AW-1:0]),
        .rdata (idata)
    );

    conv_ram #(.DEPTH(IMG_WORDS), .WIDTH(DW)) u_l0 (
        .clk   (clk),
        .we    (l0_we),
        .waddr (caddr_wr[IMG_AW-1:0]),
        .wdata (cdata_wr),
        .raddr (l0_raddr),
        .rdata (l0_rdata)
    );

    conv_ram #(.DEPTH(L1_WORDS), .WIDTH(DW)) u_l1 (
        .clk   (clk),
        .we    (l1_we),
        .waddr (caddr_wr[L1_AW-1:0]),
        .wdata (cdata_wr),
        .raddr (l1_raddr),
        .rdata (l1_rdata)
    );

    always_comb begin
        cdata_rd = '0;
        if (state_reg == RUN) begin
            if (csel == CSEL_L0) begin
                cdata_rd = l0_rdata;
            end else if (csel == CSEL_L1) begin
                cdata_rd = l1_rdata;
            end
        end
    end

    always_comb begin
        out_data = '0;
        if (in_dump) begin
            out_data = dump_l1 ? l1_rdata : l0_rdata;
        end
    end

    assign out_valid = in_dump;
    assign out_sel   = in_dump & dump_l1;
    assign out_last  = in_dump & dump_end;
    assign in_ready  = in_ready_reg;
    assign ready     = ready_reg;
    assign done      = done_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= LOAD;
            cnt_reg      <= '0;
            d_reg        <= '0;
            in_ready_reg <= 1'b0;
            ready_reg    <= 1'b0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            busy_reg <= busy;
            done_reg <= 1'b0;
            unique case (state_reg)
                LOAD: begin
                    if (img_we) begin
                        if (cnt_reg == IMG_AW'(IMG_WORDS - 1)) begin
                            in_ready_reg <= 1'b0;
                            ready_reg    <= 1'b1;
                            cnt_reg      <= '0;
                            state_reg    <= ARM;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end
                ARM: begin
                    if (busy) begin
                        ready_reg <= 1'b0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // Completion is the falling edge of busy, not its level.
                    if (busy_reg && !busy) begin
                        state_reg <= DUMP;
                    end
                end
                DUMP: begin
                    if (out_ready) begin
                        if (dump_end) begin
                            d_reg     <= '0;
                            done_reg  <= 1'b1;
                            state_reg <= FIN;
                        end else begin
                            d_reg <= d_reg + 1'b1;
                        end
                    end
                end
                FIN: begin
                    cnt_reg      <= '0;
                    d_reg        <= '0;
                    in_ready_reg <= 1'b1;
                    state_reg    <= LOAD;
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

    // Bits the engine drives that this host never needs.
    logic unused_ok;
    assign unused_ok = &{1'b0, crd, caddr_wr[AW-1:L1_AW] & 2'b00, caddr_rd[AW-1:L1_AW] & 2'b00,
                         d_l1[DCW-1:L1_AW] & 3'b000};
endmodule

// File: tb/tb_conv_host.sv
// Randomized scoreboard bench for conv_host: array reference model, queued
// expected dump beats, and a negedge monitor that pops on every transfer.
module tb_conv_host;
    import conv_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          ready;
    logic          busy = 1'b0;
    logic [AW-1:0] iaddr = '0;
    logic [DW-1:0] idata;
    logic          cwr = 1'b0;
    logic [AW-1:0] caddr_wr = '0;
    logic [DW-1:0] cdata_wr = '0;
    logic          crd = 1'b0;
    logic [AW-1:0] caddr_rd = '0;
    logic [DW-1:0] cdata_rd;
    logic [2:0]    csel = 3'b000;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_sel;
    logic          out_last;
    logic          done;

    always #5 clk = ~clk;

    conv_host dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ready     (ready),
        .busy      (busy),
        .iaddr     (iaddr),
        .idata     (idata),
        .cwr       (cwr),
        .caddr_wr  (caddr_wr),
        .cdata_wr  (cdata_wr),
        .crd       (crd),
        .caddr_rd  (caddr_rd),
        .cdata_rd  (cdata_rd),
        .csel      (csel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .done      (done)
    );

    typedef struct packed {
        logic          sel;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] img_m [IMG_WORDS];
    logic [DW-1:0] l0_m  [IMG_WORDS];
    logic [DW-1:0] l1_m  [L1_WORDS];
    beat_t         exp_q [$];
    int            n_xfer = 0;
    bit            mon_en = 1'b0;
    beat_t         held;
    bit            stalled = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented transfer against the head of the queue.
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        if (mon_en && out_valid) begin
            cur = {out_sel, out_last, out_data};
            if (stalled) chk($sformatf("dump_stable[%0d]", n_xfer), 32'(cur), 32'(held));
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dump_extra[%0d]: got 0x%0h expected no transfer", n_xfer, cur);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("dump_word[%0d]", n_xfer), 32'(cur), 32'(e));
                end
                n_xfer++;
                stalled = 1'b0;
            end else begin
                held    = cur;
                stalled = 1'b1;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic load_image(input bit ramp, input bit toggle);
        int i   = 0;
        int cyc = 0;
        while (i < IMG_WORDS && cyc < 20000) begin
            tick();
            in_valid = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            in_data  = ramp ? DW'(i) : DW'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) begin
                img_m[i] = in_data;
                i++;
            end
            cyc++;
        end
        tick();
        in_valid = 1'b0;
        $display("load: %0d words accepted in %0d cycles", i, cyc);
        chk("load_count", i, IMG_WORDS);
        @(negedge clk);
        chk("in_ready_fell", 32'(in_ready), 0);
        chk("ready_rose", 32'(ready), 1);
    endtask

    task automatic arm(input int wait_cycles);
        for (int k = 0; k < wait_cycles; k++) begin
            tick();
            @(negedge clk);
            chk("ready_hold", 32'(ready), 1);
        end
        tick();
        busy = 1'b1;
        @(negedge clk);
        chk("ready_before_sample", 32'(ready), 1);
        tick();
        @(negedge clk);
        chk("ready_drop", 32'(ready), 0);
        $display("arm: engine started after %0d idle cycles", wait_cycles);
    endtask

    task automatic fill_layers();
        for (int a = 0; a < IMG_WORDS; a++) begin
            tick();
            cwr      = 1'b1;
            csel     = CSEL_L0;
            caddr_wr = AW'(a);
            cdata_wr = DW'($urandom);
            l0_m[a]  = cdata_wr;
        end
        for (int a = 0; a < L1_WORDS; a++) begin
            tick();
            csel     = CSEL_L1;
            caddr_wr = {2'($urandom), 10'(a)};
            cdata_wr = DW'($urandom);
            l1_m[a]  = cdata_wr;
        end
        tick();
        cwr = 1'b0;
        $display("run: layer 0 and layer 1 filled with random words");
    endtask

    task automatic random_reads(input int n);
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        for (int k = 0; k < n; k++) begin
            tick();
            csel     = ($urandom_range(0, 1) == 0) ? CSEL_L0 : CSEL_L1;
            crd      = 1'b1;
            a        = AW'($urandom);
            caddr_rd = a;
            iaddr    = AW'($urandom);
            e        = (csel == CSEL_L0) ? l0_m[a] : l1_m[a[9:0]];
            @(negedge clk);
            chk("layer_read", 32'(cdata_rd), 32'(e));
            chk("image_read", 32'(idata), 32'(img_m[iaddr]));
        end
        tick();
        crd = 1'b0;
    endtask

    task automatic push_dump();
        for (int d = 0; d < DUMP_WORDS; d++) begin
            beat_t b;
            b.sel  = (d >= IMG_WORDS);
            b.last = (d == DUMP_WORDS - 1);
            b.data = (d < IMG_WORDS) ? l0_m[d] : l1_m[d - IMG_WORDS];
            exp_q.push_back(b);
        end
    endtask

    initial begin
        int k;
        logic [DW-1:0] junk;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sel", 32'(out_sel), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_done", 32'(done), 0);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("in_ready_after_release", 32'(in_ready), 1);

        // Run 1: ramp image, directed engine accesses, full dump with stalls
        load_image(1'b1, 1'b1);
        arm(10);
        tick();
        iaddr = AW'(65);
        @(negedge clk);
        chk("idata_65", 32'(idata), 32'(img_m[65]));
        $display("run: iaddr=65 idata=0x%0h", idata);
        fill_layers();

        tick();
        csel = CSEL_L0; cwr = 1'b1; crd = 1'b1;
        caddr_wr = AW'(5); cdata_wr = 20'h12345; caddr_rd = AW'(5);
        @(negedge clk);
        chk("rw_same_cycle_old", 32'(cdata_rd), 32'(l0_m[5]));
        l0_m[5] = 20'h12345;
        tick();
        cwr = 1'b0;
        @(negedge clk);
        chk("rw_next_cycle_new", 32'(cdata_rd), 32'(l0_m[5]));
        $display("run: l0[5] <= 0x12345 read back 0x%0h", cdata_rd);

        tick();
        csel = 3'b010; cwr = 1'b1;
        caddr_wr = AW'(7); cdata_wr = ~l0_m[7]; caddr_rd = AW'(7);
        @(negedge clk);
        chk("bad_csel_read_zero", 32'(cdata_rd), 0);
        tick();
        cwr = 1'b0; csel = CSEL_L0;
        @(negedge clk);
        chk("bad_csel_l0_kept", 32'(cdata_rd), 32'(l0_m[7]));
        tick();
        csel = CSEL_L1;
        @(negedge clk);
        chk("bad_csel_l1_kept", 32'(cdata_rd), 32'(l1_m[7]));
        $display("run: csel=010 write ignored");

        random_reads(16);

        tick();
        csel = CSEL_L1; cwr = 1'b1;
        caddr_wr = 12'h3FF; cdata_wr = 20'hABCDE;
        l1_m[1023] = 20'hABCDE;
        tick();
        cwr = 1'b0;

        push_dump();
        n_xfer = 0;
        mon_en = 1'b1;
        busy   = 1'b0;
        k = 0;
        while (n_xfer < DUMP_WORDS && k < 20000) begin
            tick();
            out_ready = (k % 3 != 2);
            k++;
        end
        chk("dump_count", n_xfer, DUMP_WORDS);
        @(negedge clk);
        chk("done_pulse", 32'(done), 1);
        chk("out_valid_after_dump", 32'(out_valid), 0);
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("done_single", 32'(done), 0);
        chk("in_ready_after_fin", 32'(in_ready), 1);
        chk("queue_drained", exp_q.size(), 0);
        $display("dump: %0d words transferred in %0d cycles", n_xfer, k);
        mon_en = 1'b0;

        // Run 2: random image, layer writes during load must be ignored, abort mid-dump
        junk = ~l0_m[9];
        cwr = 1'b1; csel = CSEL_L0; caddr_wr = AW'(9); cdata_wr = junk;
        load_image(1'b0, 1'b0);
        cwr = 1'b0;
        arm(2);
        random_reads(8);
        push_dump();
        n_xfer = 0;
        mon_en = 1'b1;
        busy = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (n_xfer < 100 && k < 1000) begin
            tick();
            k++;
        end
        reset = 1'b0;
        @(negedge clk);
        chk("abort_point", n_xfer, 100);
        chk("abort_in_ready", 32'(in_ready), 0);
        chk("abort_ready", 32'(ready), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_out_sel", 32'(out_sel), 0);
        chk("abort_out_last", 32'(out_last), 0);
        chk("abort_done", 32'(done), 0);
        mon_en = 1'b0;
        exp_q.delete();
        out_ready = 1'b0;
        $display("abort: reset asserted after %0d dump transfers", n_xfer);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("in_ready_after_abort", 32'(in_ready), 1);

        // Run 3: a fresh load must complete after the abort
        load_image(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
